vss_partition_flow_tdm_rx_align: RTL
====================================

Name: vss_partition_flow_tdm_rx_align

Overview:
- Framed TDM receiver for the VSS partitioning flow.
- Accepts one WIDTH-bit slot per fastclk from a partition-crossing link. Each frame is a sync slot followed by NUM_SLOTS data slots.
- Finds frame alignment by hunting for SYNC_PATTERN, confirms lock, then demultiplexes slots onto a parallel bus. The bus updates atomically once per good frame.
- Sits at the receiving partition's boundary, replacing free-running reset-aligned demuxing with self-aligning reception.

Parameters:
- WIDTH, 8, bits per TDM slot.
- NUM_SLOTS, 4, data slots per frame (≥1).
- SYNC_PATTERN, 8'hA5, sync slot value (WIDTH bits).
- LOCK_CONFIRM, 2, consecutive correct sync slots needed after the first hit before lock (≥1).
- LOSS_THRESH, 3, consecutive missed sync slots in LOCKED that drop lock (≥1).

Ports:
- fastclk  input  1  TDM slot clock.
- reset  input  1  synchronous, active-high.
- in  input  WIDTH  current slot value.
- out_data  output  NUM_SLOTS*WIDTH  published frame; slot k (1-based) at bits [k*WIDTH-1 : (k-1)*WIDTH].
- frame_valid  output  1  one-cycle pulse when out_data updates.
- locked  output  1  high in LOCKED state.
- sync_miss  output  1  one-cycle pulse on a sync mismatch while in CHECK or LOCKED.

Interface (already decided): reset reset, synchronous, active-high; clock fastclk.

Behaviour:
- Reset values:
  - state=HUNT; slot counter=0; confirm and miss counters=0.
  - out_data=0; frame_valid=0; locked=0; sync_miss=0.
  - Shadow register=0.
- Frame length F = 1+NUM_SLOTS (+1 with parity feature). Slot counter width is clog2(F) and wraps F-1→0.
- Outputs are registered. in is sampled at each posedge.
- HUNT:
  - Slot counter is held at 0. in is compared every cycle.
  - On in==SYNC_PATTERN: slot←1, confirm←0, go to CHECK.
- CHECK and LOCKED:
  - Slot counter advances every cycle.
  - Slots 1..NUM_SLOTS write in into shadow[slot-1].
  - Slot 0 is the sync check.
- CHECK, sync slot:
  - Match: confirm++. When confirm reaches LOCK_CONFIRM, go to LOCKED, locked←1, publish.
  - Mismatch: sync_miss pulse, go to HUNT. No publish.
- LOCKED, sync slot:
  - Match: miss←0, publish.
  - Mismatch: sync_miss pulse, miss++, no publish, shadow discarded. At miss==LOSS_THRESH: go to HUNT, locked←0, miss←0.
  - Slot counter keeps free-running through misses (flywheel).
- Publish:
  - out_data←shadow, and frame_valid=1 for exactly one cycle.
  - Both take effect at the same edge that samples the closing sync slot. Latency is 1 cycle after the last data slot.
  - Only frames bracketed by two matching syncs are published.
- Boundary cases:
  - Data equal to SYNC_PATTERN in a data slot while CHECK/LOCKED: treated as data.
  - Data equal to SYNC_PATTERN in HUNT: may cause false alignment, which is rejected by CHECK.
  - out_data holds its last value through misses and HUNT.
  - reset mid-frame returns everything to reset values on the next edge.
  - reset overrides all other events in the same cycle.

Optional Feature:
- Macro VSS_PARTITION_FLOW_RX_PARITY_EN.
- When defined:
  - F gains a parity slot after the data slots.
  - Expected parity is the bitwise XOR of all data slots.
  - At the closing sync, publish only if both sync and parity match.
  - Parity mismatch with good sync: no publish, pulse output parity_err (1 bit, reset 0), lock state unaffected.
- When undefined: no parity slot and no parity_err port.

Decomposition:
- Shared package vss_partition_flow_pkg holds:
  - state enum {HUNT, CHECK, LOCKED}.
  - Default SYNC_PATTERN constant.
  - Function computing F from NUM_SLOTS and the parity macro.
- One sub-module, vss_partition_flow_rx_slot_ctr: slot counter with hold, load-1, and wrap; exports sync_slot and last_data_slot flags.

Test Plan:
- Reset, then LOCK_CONFIRM+1 clean frames of [A5,11,22,33,44] → locked=1 after the third sync; frame_valid pulses; out_data=32'h44332211.
- Random garbage, then clean stream starting at an arbitrary phase → at most one CHECK abort, then lock. Payloads are never published before the bracketing sync.
- Locked stream with 2 corrupted syncs, then good → 2 sync_miss pulses, locked stays 1, no frame_valid for those frames, publish resumes.
- 3 consecutive corrupted syncs → locked=0 on the third, state HUNT, out_data holds its old value.
- Data slot containing 8'hA5 while locked → out_data carries A5 in that slot; no misalignment.
- Assert reset mid-frame while locked → all outputs 0 next cycle; relock needs the full confirm sequence.

Source files
------------

// File: rtl/vss_partition_flow_pkg.sv
// Shared definitions for the VSS partition-flow TDM receiver.
// Optional parity slot support is selected by VSS_PARTITION_FLOW_RX_PARITY_EN.
package vss_partition_flow_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  localparam logic [7:0] SYNC_PATTERN_DEFAULT = 8'hA5;

  // Slots per frame: the sync slot, the data slots and, when enabled, a parity slot.
  function automatic int frame_len(input int num_slots);
`ifdef VSS_PARTITION_FLOW_RX_PARITY_EN
    return num_slots + 2;
`else
    return num_slots + 1;
`endif
  endfunction

endpackage

// File: rtl/vss_partition_flow_rx_slot_ctr.sv
// Frame slot counter: cleared while hunting, loaded with 1 on the first sync
// hit, otherwise free-running and wrapping F-1 -> 0.
module vss_partition_flow_rx_slot_ctr #(
  parameter int NUM_SLOTS = 4,
  parameter int F         = 5,
  parameter int CW        = 3
) (
  input  logic          fastclk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load1,
  output logic [CW-1:0] slot,
  output logic          sync_slot,
  output logic          last_data_slot
);

  localparam logic [CW-1:0] SLOT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] SLOT_ONE  = CW'(1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(F - 1);
  localparam logic [CW-1:0] SLOT_DATA_LAST = CW'(NUM_SLOTS);

  // Slot position within the frame; clear wins over load1, load1 over advance.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      slot <= SLOT_ZERO;
    end else if (clear) begin
      slot <= SLOT_ZERO;
    end else if (load1) begin
      slot <= SLOT_ONE;
    end else if (slot == SLOT_LAST) begin
      slot <= SLOT_ZERO;
    end else begin
      slot <= slot + SLOT_ONE;
    end
  end

  assign sync_slot      = (slot == SLOT_ZERO);
  assign last_data_slot = (slot == SLOT_DATA_LAST);

endmodule

// File: rtl/vss_partition_flow_tdm_rx_align.sv
// Self-aligning framed TDM receiver: hunts for the sync slot, confirms lock,
// demultiplexes data slots into a shadow frame and publishes it atomically
// once the closing sync matches. A frame that follows a missed sync is
// dropped even if its closing sync is good.
// Optional parity slot: define VSS_PARTITION_FLOW_RX_PARITY_EN.
module vss_partition_flow_tdm_rx_align
  import vss_partition_flow_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               NUM_SLOTS    = 4,
  parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(SYNC_PATTERN_DEFAULT),
  parameter int               LOCK_CONFIRM = 2,
  parameter int               LOSS_THRESH  = 3
) (
  input  logic                       fastclk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  output logic [NUM_SLOTS*WIDTH-1:0] out_data,
  output logic                       frame_valid,
  output logic                       locked,
  output logic                       sync_miss
`ifdef VSS_PARTITION_FLOW_RX_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int F   = frame_len(NUM_SLOTS);
  localparam int CW  = $clog2(F);
  localparam int CFW = $clog2(LOCK_CONFIRM + 1);
  localparam int MW  = $clog2(LOSS_THRESH + 1);

  localparam logic [CFW-1:0] CONFIRM_LAST = CFW'(LOCK_CONFIRM - 1);
  localparam logic [CFW-1:0] CONFIRM_ONE  = CFW'(1);
  localparam logic [MW-1:0]  MISS_LAST    = MW'(LOSS_THRESH - 1);
  localparam logic [MW-1:0]  MISS_ONE     = MW'(1);

  rx_state_t                  state_r;
  rx_state_t                  state_nxt_s;
  logic [CW-1:0]              slot_s;
  logic                       sync_slot_s;
  logic                       last_data_slot_s;
  logic                       slot_clear_s;
  logic                       slot_load1_s;
  logic [CFW-1:0]             confirm_r;
  logic [MW-1:0]              miss_r;
  logic [NUM_SLOTS*WIDTH-1:0] shadow_r;
  logic                       frame_ok_r;
  logic                       frame_full_r;
  logic                       sync_match_s;
  logic                       in_frame_s;
  logic                       sync_check_s;
  logic                       sync_good_s;
  logic                       sync_bad_s;
  logic                       lock_point_s;
  logic                       parity_ok_s;
  logic                       publish_s;

  assign sync_match_s = (in == SYNC_PATTERN);

  vss_partition_flow_rx_slot_ctr #(
    .NUM_SLOTS (NUM_SLOTS),
    .F         (F),
    .CW        (CW)
  ) u_slot_ctr (
    .fastclk        (fastclk),
    .reset          (reset),
    .clear          (slot_clear_s),
    .load1          (slot_load1_s),
    .slot           (slot_s),
    .sync_slot      (sync_slot_s),
    .last_data_slot (last_data_slot_s)
  );

`ifdef VSS_PARTITION_FLOW_RX_PARITY_EN
  localparam logic [CW-1:0] PARITY_SLOT = CW'(F - 1);

  logic [WIDTH-1:0] parity_r;

  // XOR of every data slot of a captured frame.
  function automatic logic [WIDTH-1:0] frame_parity(input logic [NUM_SLOTS*WIDTH-1:0] frame);
    logic [WIDTH-1:0] acc;
    acc = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_SLOTS; k++) begin
      acc = acc ^ frame[k*WIDTH +: WIDTH];
    end
    return acc;
  endfunction

  assign parity_ok_s = (parity_r == frame_parity(shadow_r));

  // Capture the received parity slot and flag good-sync frames whose parity disagrees.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      parity_r   <= {WIDTH{1'b0}};
      parity_err <= 1'b0;
    end else begin
      if (in_frame_s && (slot_s == PARITY_SLOT)) begin
        parity_r <= in;
      end
      parity_err <= sync_good_s && frame_full_r && !parity_ok_s;
    end
  end
`else
  assign parity_ok_s = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and slot counter control.
  always_comb begin
    state_nxt_s  = state_r;
    slot_clear_s = 1'b0;
    slot_load1_s = 1'b0;
    case (state_r)
      HUNT: begin
        if (sync_match_s) begin
          state_nxt_s  = CHECK;
          slot_load1_s = 1'b1;
        end else begin
          slot_clear_s = 1'b1;
        end
      end
      CHECK: begin
        if (sync_slot_s && !sync_match_s) begin
          state_nxt_s  = HUNT;
          slot_clear_s = 1'b1;
        end else if (sync_slot_s && (confirm_r == CONFIRM_LAST)) begin
          state_nxt_s = LOCKED;
        end else begin
          state_nxt_s = CHECK;
        end
      end
      LOCKED: begin
        if (sync_slot_s && !sync_match_s && (miss_r == MISS_LAST)) begin
          state_nxt_s  = HUNT;
          slot_clear_s = 1'b1;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s  = HUNT;
        slot_clear_s = 1'b1;
      end
    endcase
  end

  // FSM outputs: sync-slot classification and the publish decision.
  always_comb begin
    in_frame_s   = (state_r == CHECK) || (state_r == LOCKED);
    sync_check_s = in_frame_s && sync_slot_s;
    sync_good_s  = sync_check_s && sync_match_s;
    sync_bad_s   = sync_check_s && !sync_match_s;
    lock_point_s = (state_r == CHECK) && sync_good_s && (confirm_r == CONFIRM_LAST);
    if (((state_r == LOCKED) && sync_good_s) || lock_point_s) begin
      publish_s = frame_full_r && parity_ok_s;
    end else begin
      publish_s = 1'b0;
    end
  end

  // Confirm and miss counters.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      confirm_r <= {CFW{1'b0}};
      miss_r    <= {MW{1'b0}};
    end else begin
      if (state_r == HUNT) begin
        confirm_r <= {CFW{1'b0}};
      end else if ((state_r == CHECK) && sync_good_s) begin
        confirm_r <= confirm_r + CONFIRM_ONE;
      end
      if ((state_r != LOCKED) || sync_good_s) begin
        miss_r <= {MW{1'b0}};
      end else if (sync_bad_s) begin
        miss_r <= (miss_r == MISS_LAST) ? {MW{1'b0}} : (miss_r + MISS_ONE);
      end
    end
  end

  // Shadow frame capture and tracking of whether it opened with a good sync.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      shadow_r     <= {(NUM_SLOTS*WIDTH){1'b0}};
      frame_ok_r   <= 1'b0;
      frame_full_r <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (in_frame_s && (slot_s == CW'(k + 1))) begin
          shadow_r[k*WIDTH +: WIDTH] <= in;
        end
      end
      if (state_r == HUNT) begin
        frame_ok_r <= sync_match_s;
      end else if (sync_check_s) begin
        frame_ok_r <= sync_match_s;
      end
      if ((state_r == HUNT) || sync_check_s) begin
        frame_full_r <= 1'b0;
      end else if (last_data_slot_s) begin
        frame_full_r <= frame_ok_r;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      out_data    <= {(NUM_SLOTS*WIDTH){1'b0}};
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_miss   <= 1'b0;
    end else begin
      if (publish_s) begin
        out_data <= shadow_r;
      end
      frame_valid <= publish_s;
      locked      <= (state_nxt_s == LOCKED);
      sync_miss   <= sync_bad_s;
    end
  end

endmodule
